// File: rtl/inst_prefetch_if.sv
// inst_prefetch_if -- bus bundle between the prefetch unit, instruction memory
// and the decode stage.
//
//   inst_mem_is_ready    request valid towards instruction memory
//   inst_mem_addr        request word address (PC)
//   inst_mem_req_accept  memory accepts the request this cycle
//   inst_mem_is_valid    in-order response valid
//   inst_mem_read_data   response instruction word
//   fetch_valid          entry available to decode
//   fetch_instr          instruction at queue head
//   fetch_pc             PC of fetch_instr
//   fetch_ready          decode consumes the head entry
//
// master: the prefetch unit.  slave: memory + decode side.
interface inst_prefetch_if;
    logic        inst_mem_is_ready;
    logic [31:0] inst_mem_addr;
    logic        inst_mem_req_accept;
    logic        inst_mem_is_valid;
    logic [31:0] inst_mem_read_data;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        fetch_ready;

    modport master (
        output inst_mem_is_ready, inst_mem_addr,
        input  inst_mem_req_accept, inst_mem_is_valid, inst_mem_read_data,
        output fetch_valid, fetch_instr, fetch_pc,
        input  fetch_ready
    );

    modport slave (
        input  inst_mem_is_ready, inst_mem_addr,
        output inst_mem_req_accept, inst_mem_is_valid, inst_mem_read_data,
        input  fetch_valid, fetch_instr, fetch_pc,
        output fetch_ready
    );
endinterface

// File: rtl/inst_prefetch.sv
// inst_prefetch -- sequential instruction prefetcher feeding decode.
//
// Generates sequential PCs, issues word requests to instruction memory and
// keeps returned words with their PCs in a small in-order queue presented to
// decode via a valid/ready handshake.  A redirect from execute flushes the
// queue and discards every response still in flight.
//
// Parameters:
//   RESET  PC after reset
//   DEPTH  queue entries and max outstanding requests (power of two, 2..8)
//
// Ports:
//   clk               clock
//   reset             synchronous active-high reset
//   bus               inst_prefetch_if.master (memory request/response and
//                     decode handshake)
//   redirect          single-cycle redirect pulse from execute
//   redirect_pc       redirect target
//   fetch_misaligned  sticky flag: a redirect target with [1:0] != 0 was seen
//
// Build option:
//   INST_PREFETCH_BYPASS_EN  when defined, a response arriving while the
//                            queue is empty (no drop pending, no redirect) is
//                            presented to decode in the same cycle and, if
//                            consumed, never written to the queue.
module inst_prefetch #(
    parameter logic [31:0] RESET = 32'h0000_0000,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    inst_prefetch_if.master bus,
    input  logic            redirect,
    input  logic [31:0]     redirect_pc,
    output logic            fetch_misaligned
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    // drop is not part of the issue rule, so back-to-back redirects can pile
    // up discards beyond DEPTH; give it headroom and guard with an assertion.
    localparam int unsigned DW = CW + 3;
    localparam int unsigned DROP_MAX = (1 << DW) - 1;

    logic          reset_d;
    logic [31:0]   req_pc;
    logic [CW-1:0] occupancy;
    logic [CW-1:0] outstanding;
    logic [DW-1:0] drop;

    // PCs of issued, not yet returned, non-discarded requests
    logic [31:0]   pcq [DEPTH];
    logic [AW-1:0] pcq_wr;
    logic [AW-1:0] pcq_rd;

    // instruction queue
    logic [31:0]   iq_instr [DEPTH];
    logic [31:0]   iq_pc    [DEPTH];
    logic [AW-1:0] iq_wr;
    logic [AW-1:0] iq_rd;

    logic [CW:0]   inflight;
    logic          fire;
    logic          resp_live;
    logic          resp_drop;
    logic          bypass;
    logic          push_q;
    logic          pop_q;
    logic [31:0]   resp_pc;

    always_comb begin
        inflight  = {1'b0, occupancy} + {1'b0, outstanding};
        bus.inst_mem_is_ready = !reset && !reset_d && !redirect &&
                                (inflight < (CW+1)'(DEPTH));
        bus.inst_mem_addr = req_pc;
        fire      = bus.inst_mem_is_ready && bus.inst_mem_req_accept;
        resp_drop = bus.inst_mem_is_valid && (drop != '0);
        resp_live = bus.inst_mem_is_valid && (drop == '0);
        resp_pc   = pcq[pcq_rd];
`ifdef INST_PREFETCH_BYPASS_EN
        bypass    = resp_live && (occupancy == '0) && !redirect;
`else
        bypass    = 1'b0;
`endif
        pop_q     = (occupancy != '0) && bus.fetch_ready;
        // a bypassed word that decode takes right away never enters the queue
        push_q    = resp_live && !(bypass && bus.fetch_ready);
        bus.fetch_valid = (occupancy != '0) || bypass;
        bus.fetch_instr = bypass ? bus.inst_mem_read_data : iq_instr[iq_rd];
        bus.fetch_pc    = bypass ? resp_pc : iq_pc[iq_rd];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reset_d          <= 1'b1;
            req_pc           <= RESET;
            occupancy        <= '0;
            outstanding      <= '0;
            drop             <= '0;
            pcq_wr           <= '0;
            pcq_rd           <= '0;
            iq_wr            <= '0;
            iq_rd            <= '0;
            fetch_misaligned <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                iq_instr[i] <= '0;
                iq_pc[i]    <= '0;
            end
        end else begin
            reset_d <= 1'b0;
            if (redirect) begin
                // Everything in flight becomes a discard, including a live
                // response arriving in this very cycle.
                req_pc      <= {redirect_pc[31:2], 2'b00};
                occupancy   <= '0;
                outstanding <= '0;
                pcq_wr      <= '0;
                pcq_rd      <= '0;
                iq_wr       <= '0;
                iq_rd       <= '0;
                drop        <= drop - DW'(resp_drop) + DW'(outstanding) - DW'(resp_live);
                if (redirect_pc[1:0] != 2'b00) begin
                    fetch_misaligned <= 1'b1;
                end
            end else begin
                if (fire) begin
                    pcq[pcq_wr] <= req_pc;
                    pcq_wr      <= pcq_wr + 1'b1;
                    req_pc      <= req_pc + 32'd4;
                end
                if (resp_drop) begin
                    drop <= drop - 1'b1;
                end
                if (resp_live) begin
                    pcq_rd <= pcq_rd + 1'b1;
                end
                if (push_q) begin
                    iq_instr[iq_wr] <= bus.inst_mem_read_data;
                    iq_pc[iq_wr]    <= resp_pc;
                    iq_wr           <= iq_wr + 1'b1;
                end
                if (pop_q) begin
                    iq_rd <= iq_rd + 1'b1;
                end
                outstanding <= outstanding + CW'(fire) - CW'(resp_live);
                occupancy   <= occupancy + CW'(push_q) - CW'(pop_q);
            end
        end
    end

    assert property (@(posedge clk) disable iff (reset)
        inflight <= (CW+1)'(DEPTH));
    assert property (@(posedge clk) disable iff (reset)
        bus.inst_mem_is_valid |-> (drop != '0 || outstanding != '0));
    assert property (@(posedge clk) disable iff (reset)
        redirect |-> (({1'b0, drop} + (DW+1)'(outstanding)) <= (DW+1)'(DROP_MAX)));
endmodule

// File: tb/tb_inst_prefetch.sv
module tb_inst_prefetch;
    localparam int unsigned DEPTH = 2;
`ifdef INST_PREFETCH_BYPASS_EN
    localparam int FILL_LAT = 0;
`else
    localparam int FILL_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mis;
    logic        mis2;

    inst_prefetch_if bus ();
    inst_prefetch_if bus2 ();

    always #5 clk = ~clk;

    inst_prefetch #(.RESET(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .bus(bus), .redirect(redirect),
        .redirect_pc(redirect_pc), .fetch_misaligned(mis));

    inst_prefetch #(.RESET(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .reset(reset), .bus(bus2), .redirect(1'b0),
        .redirect_pc(32'h0), .fetch_misaligned(mis2));

    int n_tests = 0;
    int n_fail  = 0;

    // memory model: in-order pending requests with earliest response cycle
    logic [31:0] mq_addr [$];
    int          mq_t    [$];
    int          cyc = 0;
    int unsigned acc_pct, vld_pct, rdy_pct, lat_max;

    // reference model of the fetch stream
    logic        rd_req = 1'b0;
    logic [31:0] rd_target = '0;
    logic [31:0] exp_pc, next_req;
    int          live;
    logic        mis_exp, prev_redir, hold, want_first;
    logic [31:0] hold_pc, hold_instr, first_pc_after;
    int          consumed, issued, first_resp_cyc, first_valid_cyc;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_A5A5;
    endfunction

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            logic exp_rdy;
            @(negedge clk);
            cyc++;
            bus.inst_mem_req_accept = ($urandom_range(99) < acc_pct);
            if (mq_addr.size() != 0 && mq_t[0] <= cyc && $urandom_range(99) < vld_pct) begin
                bus.inst_mem_is_valid  = 1'b1;
                bus.inst_mem_read_data = instr_of(mq_addr[0]);
            end else begin
                bus.inst_mem_is_valid  = 1'b0;
                bus.inst_mem_read_data = $urandom;
            end
            bus.fetch_ready = ($urandom_range(99) < rdy_pct);
            redirect    = rd_req && !prev_redir;
            redirect_pc = rd_target;
            if (redirect) rd_req = 1'b0;
            #1;
            exp_rdy = !redirect && (live < int'(DEPTH));
            n_tests++;
            if (bus.inst_mem_is_ready !== exp_rdy)
                $display("FAIL issue_rule @%0d: got %b, expected %b", cyc, bus.inst_mem_is_ready, exp_rdy);
            if (bus.inst_mem_is_ready === 1'b1 && bus.inst_mem_req_accept) begin
                n_tests++;
                if (bus.inst_mem_addr !== next_req) begin
                    n_fail++;
                    $display("FAIL req_addr @%0d: got %h, expected %h", cyc, bus.inst_mem_addr, next_req);
                end
                mq_addr.push_back(bus.inst_mem_addr);
                mq_t.push_back(cyc + 1 + int'($urandom_range(lat_max)));
                next_req += 32'd4;
                live++;
                issued++;
            end
            if (bus.inst_mem_is_ready !== exp_rdy) n_fail++;
            if (bus.inst_mem_is_valid) begin
                void'(mq_addr.pop_front());
                void'(mq_t.pop_front());
                if (first_resp_cyc < 0) first_resp_cyc = cyc;
            end
            if (prev_redir) begin
                n_tests++;
                if (bus.fetch_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL valid_after_redirect @%0d: got %b, expected 0", cyc, bus.fetch_valid);
                end
            end
            if (hold) begin
                n_tests++;
                if (bus.fetch_valid !== 1'b1 || bus.fetch_pc !== hold_pc || bus.fetch_instr !== hold_instr) begin
                    n_fail++;
                    $display("FAIL head_stable @%0d: got v=%b pc=%h instr=%h, expected v=1 pc=%h instr=%h",
                             cyc, bus.fetch_valid, bus.fetch_pc, bus.fetch_instr, hold_pc, hold_instr);
                end
            end
            hold = 1'b0;
            if (bus.fetch_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bus.fetch_valid === 1'b1 && bus.fetch_ready) begin
                n_tests++;
                if (bus.fetch_pc !== exp_pc || bus.fetch_instr !== instr_of(exp_pc)) begin
                    n_fail++;
                    $display("FAIL fetch_order @%0d: got pc=%h instr=%h, expected pc=%h instr=%h",
                             cyc, bus.fetch_pc, bus.fetch_instr, exp_pc, instr_of(exp_pc));
                end
                if (want_first) begin
                    first_pc_after = bus.fetch_pc;
                    want_first = 1'b0;
                end
                exp_pc += 32'd4;
                live--;
                consumed++;
            end else if (bus.fetch_valid === 1'b1 && !redirect) begin
                hold       = 1'b1;
                hold_pc    = bus.fetch_pc;
                hold_instr = bus.fetch_instr;
            end
            n_tests++;
            if (mis !== mis_exp) begin
                n_fail++;
                $display("FAIL misaligned_flag @%0d: got %b, expected %b", cyc, mis, mis_exp);
            end
            if (redirect) begin
                live           = 0;
                exp_pc         = {rd_target[31:2], 2'b00};
                next_req       = exp_pc;
                if (rd_target[1:0] != 2'b00) mis_exp = 1'b1;
                want_first     = 1'b1;
                first_pc_after = 'x;
                hold           = 1'b0;
            end
            prev_redir = redirect;
        end
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk);
        reset    = 1'b1;
        redirect = 1'b0;
        rd_req   = 1'b0;
        bus.inst_mem_req_accept  = 1'b0;
        bus.inst_mem_is_valid    = 1'b0;
        bus.fetch_ready          = 1'b0;
        bus2.inst_mem_req_accept = 1'b0;
        bus2.inst_mem_is_valid   = 1'b0;
        bus2.inst_mem_read_data  = '0;
        bus2.fetch_ready         = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Releases reset; the memory is offered an accept in this first cycle so
    // that any premature issue would desynchronise the request addresses.
    task automatic release_reset();
        reset = 1'b0;
        bus.inst_mem_req_accept = 1'b1;
        mq_addr.delete();
        mq_t.delete();
        live = 0; exp_pc = '0; next_req = '0; mis_exp = 1'b0;
        prev_redir = 1'b0; hold = 1'b0; want_first = 1'b0;
        consumed = 0; issued = 0; first_resp_cyc = -1; first_valid_cyc = -1;
        #1;
    endtask

    task automatic test_reset();
        apply_reset(3);
        n_tests += 6;
        if (bus.inst_mem_is_ready !== 1'b0) begin n_fail++; $display("FAIL rst_is_ready: got %b, expected 0", bus.inst_mem_is_ready); end
        if (bus.inst_mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h, expected 00000000", bus.inst_mem_addr); end
        if (bus.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL rst_fetch_valid: got %b, expected 0", bus.fetch_valid); end
        if (bus.fetch_instr !== 32'h0) begin n_fail++; $display("FAIL rst_fetch_instr: got %h, expected 00000000", bus.fetch_instr); end
        if (bus.fetch_pc !== 32'h0) begin n_fail++; $display("FAIL rst_fetch_pc: got %h, expected 00000000", bus.fetch_pc); end
        if (mis !== 1'b0) begin n_fail++; $display("FAIL rst_misaligned: got %b, expected 0", mis); end
        release_reset();
        n_tests++;
        if (bus.inst_mem_is_ready !== 1'b0) begin n_fail++; $display("FAIL first_cycle_no_issue: got %b, expected 0", bus.inst_mem_is_ready); end
    endtask

    task automatic test_stream();
        acc_pct = 100; vld_pct = 100; rdy_pct = 100; lat_max = 0;
        run_cycles(16);
        n_tests += 2;
        if (consumed < 4) begin n_fail++; $display("FAIL stream_count: got %0d, expected at least 4", consumed); end
        if (first_valid_cyc - first_resp_cyc != FILL_LAT) begin
            n_fail++;
            $display("FAIL fill_latency: got %0d, expected %0d", first_valid_cyc - first_resp_cyc, FILL_LAT);
        end
    endtask

    task automatic test_backpressure();
        apply_reset(1);
        release_reset();
        acc_pct = 100; vld_pct = 100; rdy_pct = 0; lat_max = 0;
        run_cycles(10);
        n_tests += 5;
        if (issued != int'(DEPTH)) begin n_fail++; $display("FAIL buffered_count: got %0d, expected %0d", issued, DEPTH); end
        if (mq_addr.size() != 0) begin n_fail++; $display("FAIL outstanding_zero: got %0d, expected 0", mq_addr.size()); end
        if (bus.inst_mem_is_ready !== 1'b0) begin n_fail++; $display("FAIL issue_blocked: got %b, expected 0", bus.inst_mem_is_ready); end
        if (bus.fetch_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b, expected 1", bus.fetch_valid); end
        if (bus.fetch_pc !== 32'h0) begin n_fail++; $display("FAIL bp_head_pc: got %h, expected 00000000", bus.fetch_pc); end
        rdy_pct = 100;
        run_cycles(10);
        n_tests++;
        if (consumed < 3) begin n_fail++; $display("FAIL release_count: got %0d, expected at least 3", consumed); end
    endtask

    task automatic test_redirect();
        apply_reset(1);
        release_reset();
        acc_pct = 100; vld_pct = 0; rdy_pct = 100; lat_max = 0;
        run_cycles(4);
        n_tests++;
        if (mq_addr.size() != 2) begin n_fail++; $display("FAIL redirect_setup_outstanding: got %0d, expected 2", mq_addr.size()); end
        vld_pct = 100; rd_req = 1'b1; rd_target = 32'h0000_0100;
        run_cycles(12);
        n_tests += 2;
        if (first_pc_after !== 32'h0000_0100) begin n_fail++; $display("FAIL redirect_target: got %h, expected 00000100", first_pc_after); end
        if (mis !== 1'b0) begin n_fail++; $display("FAIL redirect_aligned_flag: got %b, expected 0", mis); end
    endtask

    task automatic test_misaligned();
        acc_pct = 70; vld_pct = 70; rdy_pct = 70; lat_max = 2;
        run_cycles(10);
        rd_req = 1'b1; rd_target = 32'h0000_0202;
        run_cycles(30);
        n_tests += 2;
        if (first_pc_after !== 32'h0000_0200) begin n_fail++; $display("FAIL misaligned_target: got %h, expected 00000200", first_pc_after); end
        if (mis !== 1'b1) begin n_fail++; $display("FAIL misaligned_set: got %b, expected 1", mis); end
        rd_req = 1'b1; rd_target = 32'h0000_0400;
        run_cycles(20);
        n_tests++;
        if (mis !== 1'b1) begin n_fail++; $display("FAIL misaligned_sticky: got %b, expected 1", mis); end
    endtask

    task automatic test_random();
        int start;
        start = consumed;
        for (int b = 0; b < 60; b++) begin
            acc_pct = $urandom_range(100, 20);
            vld_pct = $urandom_range(100, 20);
            rdy_pct = $urandom_range(100, 10);
            lat_max = $urandom_range(4);
            if ($urandom_range(2) != 0) begin
                rd_req = 1'b1;
                case ($urandom_range(9))
                    0:       rd_target = 32'hFFFF_FFF0;
                    1:       rd_target = $urandom | 32'h1;
                    default: rd_target = $urandom & ~32'h3;
                endcase
            end
            run_cycles(50);
        end
        n_tests++;
        if (consumed - start <= 0) begin n_fail++; $display("FAIL random_progress: got %0d, expected > 0", consumed - start); end
    endtask

    task automatic test_reset_midop();
        acc_pct = 100; vld_pct = 50; rdy_pct = 0; lat_max = 1;
        run_cycles(8);
        apply_reset(1);
        n_tests += 6;
        if (bus.inst_mem_is_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_is_ready: got %b, expected 0", bus.inst_mem_is_ready); end
        if (bus.inst_mem_addr !== 32'h0) begin n_fail++; $display("FAIL midrst_addr: got %h, expected 00000000", bus.inst_mem_addr); end
        if (bus.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_fetch_valid: got %b, expected 0", bus.fetch_valid); end
        if (bus.fetch_instr !== 32'h0) begin n_fail++; $display("FAIL midrst_fetch_instr: got %h, expected 00000000", bus.fetch_instr); end
        if (bus.fetch_pc !== 32'h0) begin n_fail++; $display("FAIL midrst_fetch_pc: got %h, expected 00000000", bus.fetch_pc); end
        if (mis !== 1'b0) begin n_fail++; $display("FAIL midrst_misaligned: got %b, expected 0", mis); end
        release_reset();
        n_tests++;
        if (bus.inst_mem_is_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_first_cycle: got %b, expected 0", bus.inst_mem_is_ready); end
        acc_pct = 100; vld_pct = 100; rdy_pct = 100; lat_max = 0;
        run_cycles(12);
        n_tests++;
        if (consumed < 4) begin n_fail++; $display("FAIL midrst_refetch: got %0d, expected at least 4", consumed); end
    endtask

    task automatic test_wrap();
        logic [31:0] q2 [$];
        logic [31:0] pcs [$];
        logic [31:0] ins [$];
        logic [31:0] exp_w [3];
        exp_w[0] = 32'hFFFF_FFF8;
        exp_w[1] = 32'hFFFF_FFFC;
        exp_w[2] = 32'h0000_0000;
        apply_reset(2);
        n_tests++;
        if (bus2.inst_mem_addr !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_rst_addr: got %h, expected fffffff8", bus2.inst_mem_addr); end
        release_reset();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            bus2.inst_mem_req_accept = 1'b1;
            bus2.fetch_ready = 1'b1;
            bus2.inst_mem_is_valid = (q2.size() != 0);
            bus2.inst_mem_read_data = (q2.size() != 0) ? instr_of(q2[0]) : 32'h0;
            #1;
            if (bus2.inst_mem_is_valid) void'(q2.pop_front());
            if (bus2.inst_mem_is_ready === 1'b1) q2.push_back(bus2.inst_mem_addr);
            if (bus2.fetch_valid === 1'b1) begin
                pcs.push_back(bus2.fetch_pc);
                ins.push_back(bus2.fetch_instr);
            end
        end
        n_tests++;
        if (pcs.size() < 3) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d, expected at least 3", pcs.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (pcs[i] !== exp_w[i] || ins[i] !== instr_of(exp_w[i])) begin
                    n_fail++;
                    $display("FAIL wrap_seq[%0d]: got pc=%h instr=%h, expected pc=%h instr=%h",
                             i, pcs[i], ins[i], exp_w[i], instr_of(exp_w[i]));
                end
            end
        end
    endtask

    initial begin
        bus.inst_mem_req_accept  = 1'b0;
        bus.inst_mem_is_valid    = 1'b0;
        bus.inst_mem_read_data   = '0;
        bus.fetch_ready          = 1'b0;
        bus2.inst_mem_req_accept = 1'b0;
        bus2.inst_mem_is_valid   = 1'b0;
        bus2.inst_mem_read_data  = '0;
        bus2.fetch_ready         = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_misaligned();
        test_random();
        test_reset_midop();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
